// File: rtl/vga_win_arbiter.sv
// vga_win_arbiter: per-pixel source selection between N_WIN rectangular
// colour windows and a background colour. Configuration is written into a
// staging bank and copied into the active bank in a single cycle on the
// rising edge of vsync, so a frame never shows a half-updated window set.
// The hit test and priority pick are combinational; the result is
// registered once, giving one cycle from pix_x/pix_y to pix_data.
module vga_win_arbiter #(
   parameter int N_WIN   = 4,
   parameter int COORD_W = 10,
   parameter int RGB_W   = 16
) (
   input  logic               vga_clk,
   input  logic               sys_rst,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic               vsync,
   input  logic               cfg_wr,
   input  logic [5:0]         cfg_addr,
   input  logic [15:0]        cfg_wdata,
   output logic [RGB_W-1:0]   pix_data,
   output logic [2:0]         win_id,
   output logic               cfg_pend,
   output logic [15:0]        frame_cnt
);

   // One window's register set; x_end and y_end are exclusive bounds.
   typedef struct packed {
      logic               en;
      logic [COORD_W-1:0] x_start;
      logic [COORD_W-1:0] x_end;
      logic [COORD_W-1:0] y_start;
      logic [COORD_W-1:0] y_end;
      logic [RGB_W-1:0]   colour;
   } win_t;

   localparam logic [2:0] FLD_X_START = 3'd0;
   localparam logic [2:0] FLD_X_END   = 3'd1;
   localparam logic [2:0] FLD_Y_START = 3'd2;
   localparam logic [2:0] FLD_Y_END   = 3'd3;
   localparam logic [2:0] FLD_COLOUR  = 3'd4;
   localparam logic [2:0] FLD_CTRL    = 3'd5;
   localparam logic [2:0] NO_HIT_ID   = 3'b100;

   win_t             stg_win [N_WIN];
   win_t             act_win [N_WIN];
   logic [RGB_W-1:0] stg_bg;
   logic [RGB_W-1:0] act_bg;
   logic             vsync_d;

   logic             commit;
   logic [1:0]       win_sel;
   logic [2:0]       field;
   logic             win_ok;
   logic             wr_win;
   logic             wr_bg;
   logic             wr_acc;
   logic             unused_wdata;

   logic [N_WIN-1:0] hit_p0;
   logic             blank_p0;
   logic [RGB_W-1:0] pix_p0;
   logic [2:0]       id_p0;

   // Half-open interval test: lo <= v < hi; an empty range never matches.
   function automatic logic in_span(input logic [COORD_W-1:0] v,
                                    input logic [COORD_W-1:0] lo,
                                    input logic [COORD_W-1:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

   // Config data is 16 bits wide; coordinates keep only their low bits.
   function automatic logic [COORD_W-1:0] to_coord(input logic [15:0] d);
      return COORD_W'(d);
   endfunction

   function automatic logic [RGB_W-1:0] to_rgb(input logic [15:0] d);
      return RGB_W'(d);
   endfunction

   // Only the enable bit of ctrl and the low bits of coordinates are kept.
   assign unused_wdata = ^cfg_wdata;

   // Decode the config strobe; only writes that land in a real register count.
   always_comb begin
      commit  = vsync & ~vsync_d;
      win_sel = cfg_addr[4:3];
      field   = cfg_addr[2:0];
      win_ok  = (int'(win_sel) < N_WIN);
      wr_win  = cfg_wr & ~cfg_addr[5] & win_ok & (field <= FLD_CTRL);
      wr_bg   = cfg_wr &  cfg_addr[5] & (field == 3'd0);
      wr_acc  = wr_win | wr_bg;
   end

   // Staging bank: the only target of config writes, never stalls.
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         for (int i = 0; i < N_WIN; i++) begin
            stg_win[i] <= '0;
         end
         stg_bg <= '0;
      end else begin
         if (wr_bg) begin
            stg_bg <= to_rgb(cfg_wdata);
         end
         if (wr_win) begin
            case (field)
               FLD_X_START: stg_win[win_sel].x_start <= to_coord(cfg_wdata);
               FLD_X_END:   stg_win[win_sel].x_end   <= to_coord(cfg_wdata);
               FLD_Y_START: stg_win[win_sel].y_start <= to_coord(cfg_wdata);
               FLD_Y_END:   stg_win[win_sel].y_end   <= to_coord(cfg_wdata);
               FLD_COLOUR:  stg_win[win_sel].colour  <= to_rgb(cfg_wdata);
               FLD_CTRL:    stg_win[win_sel].en      <= cfg_wdata[0];
               default:     ;
            endcase
         end
      end
   end

   // Active bank: copied from staging as a whole on the vsync rising edge.
   // A write in the commit cycle is not visible here until the next commit,
   // because the copy samples staging before that write lands.
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         for (int i = 0; i < N_WIN; i++) begin
            act_win[i] <= '0;
         end
         act_bg <= '0;
      end else if (commit) begin
         for (int i = 0; i < N_WIN; i++) begin
            act_win[i] <= stg_win[i];
         end
         act_bg <= stg_bg;
      end
   end

   // Commit tracking: vsync edge detect, pending flag and frame counter.
   // A write in the commit cycle keeps cfg_pend set since it is not yet active.
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         vsync_d   <= 1'b0;
         cfg_pend  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         vsync_d <= vsync;
         if (wr_acc) begin
            cfg_pend <= 1'b1;
         end else if (commit) begin
            cfg_pend <= 1'b0;
         end
         if (commit) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   // Stage p0: per-window hit test against the active bank.
   always_comb begin
      blank_p0 = (&pix_x) | (&pix_y);
      for (int i = 0; i < N_WIN; i++) begin
         hit_p0[i] = act_win[i].en
                   & in_span(pix_x, act_win[i].x_start, act_win[i].x_end)
                   & in_span(pix_y, act_win[i].y_start, act_win[i].y_end);
      end
   end

   // Priority pick: scanning from the top index down lets the lowest hit win.
   always_comb begin
      pix_p0 = act_bg;
      id_p0  = NO_HIT_ID;
      for (int i = N_WIN - 1; i >= 0; i--) begin
         if (hit_p0[i]) begin
            pix_p0 = act_win[i].colour;
            id_p0  = {1'b0, 2'(i)};
         end
      end
      if (blank_p0) begin
         pix_p0 = '0;
         id_p0  = NO_HIT_ID;
      end
   end

   // Stage p1: output register, one cycle after the coordinate request.
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         pix_data <= '0;
         win_id   <= NO_HIT_ID;
      end else begin
         pix_data <= pix_p0;
         win_id   <= id_p0;
      end
   end

endmodule

// File: tb/tb_vga_win_arbiter.sv
// Testbench for vga_win_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a register-file level model.
module tb_vga_win_arbiter;

   logic        clk;
   logic        rst;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        vsync;
   logic        cfg_wr;
   logic [5:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic [15:0] pix_data;
   logic [2:0]  win_id;
   logic        cfg_pend;
   logic [15:0] frame_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: register file by [window][field], staging and active copies.
   int m_stg [4][6];
   int m_act [4][6];
   int m_stg_bg, m_act_bg;
   bit m_prev_vs;
   bit m_pend;
   int m_fc;
   int e_pix, e_id;

   vga_win_arbiter #(.N_WIN(4), .COORD_W(10), .RGB_W(16)) dut (
      .vga_clk  (clk),
      .sys_rst  (rst),
      .pix_x    (pix_x),
      .pix_y    (pix_y),
      .vsync    (vsync),
      .cfg_wr   (cfg_wr),
      .cfg_addr (cfg_addr),
      .cfg_wdata(cfg_wdata),
      .pix_data (pix_data),
      .win_id   (win_id),
      .cfg_pend (cfg_pend),
      .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int fmask(input int f, input int d);
      if (f < 4) return d & 'h3ff;
      if (f == 4) return d & 'hffff;
      return d & 1;
   endfunction

   // One clock of the reference behaviour, using the inputs seen at the edge.
   task automatic model_step();
      bit commit;
      bit acc;
      int w, f;
      if (rst) begin
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 6; j++) begin
               m_stg[i][j] = 0;
               m_act[i][j] = 0;
            end
         m_stg_bg = 0; m_act_bg = 0; m_prev_vs = 0; m_pend = 0; m_fc = 0;
         e_pix = 0; e_id = 4;
         return;
      end
      if (pix_x == 10'h3ff || pix_y == 10'h3ff) begin
         e_pix = 0; e_id = 4;
      end else begin
         e_pix = m_act_bg; e_id = 4;
         for (int i = 3; i >= 0; i--) begin
            if (m_act[i][5] == 1 &&
                int'(pix_x) >= m_act[i][0] && int'(pix_x) < m_act[i][1] &&
                int'(pix_y) >= m_act[i][2] && int'(pix_y) < m_act[i][3]) begin
               e_pix = m_act[i][4]; e_id = i;
            end
         end
      end
      commit = vsync && !m_prev_vs;
      m_prev_vs = vsync;
      if (commit) begin
         m_act = m_stg;
         m_act_bg = m_stg_bg;
      end
      acc = 0;
      if (cfg_wr) begin
         w = int'(cfg_addr[4:3]);
         f = int'(cfg_addr[2:0]);
         if (cfg_addr[5]) begin
            if (f == 0) begin m_stg_bg = int'(cfg_wdata); acc = 1; end
         end else if (f <= 5) begin
            m_stg[w][f] = fmask(f, int'(cfg_wdata)); acc = 1;
         end
      end
      if (acc) m_pend = 1;
      else if (commit) m_pend = 0;
      if (commit) m_fc = (m_fc + 1) & 'hffff;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("pix", pix_data, e_pix);
      chk("id", win_id, e_id);
      chk("pend", cfg_pend, m_pend);
      chk("fcnt", frame_cnt, m_fc);
      cfg_wr = 1'b0;
   endtask

   task automatic wr(input int w, input int f, input int d);
      cfg_wr = 1'b1; cfg_addr = 6'((w << 3) | f); cfg_wdata = 16'(d);
      tick();
   endtask

   task automatic wr_bg(input int d);
      cfg_wr = 1'b1; cfg_addr = 6'h20; cfg_wdata = 16'(d);
      tick();
   endtask

   task automatic win(input int w, input int xs, input int ys, input int xe,
                      input int ye, input int col, input int en);
      wr(w, 0, xs); wr(w, 1, xe); wr(w, 2, ys); wr(w, 3, ye);
      wr(w, 4, col); wr(w, 5, en);
   endtask

   task automatic pulse_vsync();
      vsync = 1'b1; tick();
      vsync = 1'b0; tick();
   endtask

   task automatic at(input int x, input int y);
      pix_x = 10'(x); pix_y = 10'(y);
      tick();
   endtask

   initial begin
      rst = 1'b1; pix_x = '0; pix_y = '0; vsync = 1'b0;
      cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      tick(); tick();
      chk("rst_pix", pix_data, 16'h0);
      chk("rst_id", win_id, 3'b100);
      chk("rst_pend", cfg_pend, 1'b0);
      chk("rst_fcnt", frame_cnt, 16'h0);
      rst = 1'b0;

      // Sweep with nothing configured.
      for (int x = 0; x < 640; x++) at(x, 0);
      chk("t1_pix", pix_data, 16'h0);
      chk("t1_id", win_id, 3'b100);

      // Single window, staged then committed.
      pix_x = 10'd15; pix_y = 10'd25;
      win(0, 10, 20, 30, 40, 'hF800, 1);
      wr_bg('h001F);
      tick();
      chk("t2_pend", cfg_pend, 1'b1);
      chk("t2_precommit_id", win_id, 3'b100);
      pulse_vsync();
      chk("t2_fcnt", frame_cnt, 16'd1);
      chk("t2_pend_clr", cfg_pend, 1'b0);
      at(10, 20);
      chk("t2_in_pix", pix_data, 16'hF800);
      chk("t2_in_id", win_id, 3'b000);
      at(30, 20);
      chk("t2_xend_pix", pix_data, 16'h001F);
      chk("t2_xend_id", win_id, 3'b100);

      // Overlapping windows, lower index wins.
      win(0, 0, 0, 100, 100, 'hF800, 1);
      win(1, 50, 50, 200, 200, 'h07E0, 1);
      pulse_vsync();
      at(60, 60);
      chk("t3_ov_pix", pix_data, 16'hF800);
      chk("t3_ov_id", win_id, 3'b000);
      at(150, 150);
      chk("t3_w1_pix", pix_data, 16'h07E0);
      chk("t3_w1_id", win_id, 3'b001);
      at(300, 300);
      chk("t3_bg_pix", pix_data, 16'h001F);
      chk("t3_bg_id", win_id, 3'b100);

      // Write coinciding with the commit cycle.
      pix_x = 10'd60; pix_y = 10'd60;
      vsync = 1'b1; cfg_wr = 1'b1; cfg_addr = 6'h04; cfg_wdata = 16'h07E0;
      tick();
      tick();
      chk("t4_old_pix", pix_data, 16'hF800);
      chk("t4_pend", cfg_pend, 1'b1);
      vsync = 1'b0; tick();
      vsync = 1'b1; tick();
      tick();
      chk("t4_new_pix", pix_data, 16'h07E0);
      chk("t4_pend_clr", cfg_pend, 1'b0);
      vsync = 1'b0; tick();

      // Inactive coordinate and empty window.
      win(0, 0, 0, 'h3ff, 200, 'hF800, 1);
      pulse_vsync();
      at('h3ff, 5);
      chk("t5_blank_pix", pix_data, 16'h0);
      chk("t5_blank_id", win_id, 3'b100);
      win(0, 5, 5, 5, 5, 'hF800, 1);
      pulse_vsync();
      at(5, 5);
      chk("t5_empty_id", win_id, 3'b100);

      // Mid-frame reset.
      at(60, 60);
      chk("t6_pre_id", win_id, 3'b001);
      rst = 1'b1; tick();
      chk("t6_rst_pix", pix_data, 16'h0);
      chk("t6_rst_fcnt", frame_cnt, 16'h0);
      rst = 1'b0;
      pulse_vsync();
      at(60, 60);
      chk("t6_dis_id", win_id, 3'b100);

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         int f;
         rst = ($urandom_range(0, 599) == 0);
         vsync = ($urandom_range(0, 19) == 0) ? ~vsync : vsync;
         pix_x = ($urandom_range(0, 15) == 0) ? 10'h3ff : 10'($urandom_range(0, 300));
         pix_y = ($urandom_range(0, 15) == 0) ? 10'h3ff : 10'($urandom_range(0, 300));
         if ($urandom_range(0, 3) == 0) begin
            cfg_wr = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
               cfg_addr = 6'h20;
               cfg_wdata = 16'($urandom);
            end else begin
               f = $urandom_range(0, 5);
               cfg_addr = 6'(($urandom_range(0, 3) << 3) | f);
               cfg_wdata = (f < 4) ? 16'($urandom_range(0, 320)) :
                           (f == 4) ? 16'($urandom) : 16'($urandom_range(0, 3));
            end
         end
         tick();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
